rwt_up_reg_bank: RTL

- Synthesizable up-bus register slave: a parametrised bank of NUM_REGS 32-bit registers at BASE_ADDR.
- Per-register mode: read/write, read-only status, or write-1-to-clear with hardware set.
- Programmable read and write wait states.
- Used in cores as the control/status bank behind the up_wreq/up_rreq interface; rdata is zero when idle so several banks can be OR-combined.

---
 rtl/rwt_up_reg_bank.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rwt_up_reg_bank.sv
// Register bank that answers up_wreq/up_raddr requests. Each register is read/write,
// read-only status, or write-1-to-clear with a hardware set. Wait states are programmable.
module rwt_up_reg_bank #(
    parameter int                       ADDRESS_WIDTH = 14,
    parameter int                       NUM_REGS      = 32,
    parameter int                       BASE_ADDR     = 0,
    parameter int                       WR_LATENCY    = 0,
    parameter int                       RD_LATENCY    = 0,
    parameter logic [NUM_REGS-1:0]      RO_MASK       = '0,
    parameter logic [NUM_REGS-1:0]      W1C_MASK      = '0,
    parameter logic [NUM_REGS*32-1:0]   RESET_VALUES  = '0
) (
    input  logic                       up_clk,
    input  logic                       up_rstn,
    input  logic                       up_wreq,
    input  logic [ADDRESS_WIDTH-1:0]   up_waddr,
    input  logic [31:0]                up_wdata,
    output logic                       up_wack,
    input  logic                       up_rreq,
    input  logic [ADDRESS_WIDTH-1:0]   up_raddr,
    output logic [31:0]                up_rdata,
    output logic                       up_rack,
    output logic [NUM_REGS*32-1:0]     reg_out,
    input  logic [NUM_REGS*32-1:0]     reg_in,
    input  logic [NUM_REGS*32-1:0]     hw_set,
    output logic [NUM_REGS-1:0]        reg_wr_strobe,
    output logic [NUM_REGS-1:0]        reg_rd_strobe,
    output logic [1:0]                 wr_state_dbg,
    output logic [1:0]                 rd_state_dbg
);

    // Handshake: a req pulse is sampled only while its channel is IDLE; the matching
    // ack pulses high for one cycle 1+LATENCY cycles later, and up_rdata is nonzero
    // only in that rack cycle. Requests arriving while a channel is busy are dropped.

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int AW1   = ADDRESS_WIDTH + 1;
    localparam logic [AW1-1:0] ADDR_LO = AW1'(BASE_ADDR);
    localparam logic [AW1-1:0] ADDR_HI = AW1'(BASE_ADDR + NUM_REGS);
    localparam logic [3:0]     WR_LAT  = 4'(WR_LATENCY);
    localparam logic [3:0]     RD_LAT  = 4'(RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return ({1'b0, a} >= ADDR_LO) && ({1'b0, a} < ADDR_HI);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDRESS_WIDTH-1:0] a);
        return IDX_W'({1'b0, a} - ADDR_LO);
    endfunction

    state_t                     wr_state, rd_state;
    logic [3:0]                 wr_cnt, rd_cnt;
    logic [ADDRESS_WIDTH-1:0]   waddr_q, raddr_q;
    logic [31:0]                wdata_q;

    logic                       wr_go, rd_go;
    logic [ADDRESS_WIDTH-1:0]   wr_addr_c, rd_addr_c;
    logic [31:0]                wr_data_c;
    logic [NUM_REGS-1:0]        wr_hit, rd_hit;
    logic [31:0]                rd_src [NUM_REGS];
    logic [31:0]                rd_val;
    logic                       unused_bits;

    assign unused_bits  = ^{reg_in, hw_set};
    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

    // With zero latency the commit edge is also the sampling edge, so use the live bus.
    always_comb begin
        wr_addr_c = (wr_state == ST_IDLE) ? up_waddr : waddr_q;
        wr_data_c = (wr_state == ST_IDLE) ? up_wdata : wdata_q;
        wr_go     = 1'b0;
        if (wr_state == ST_IDLE)
            wr_go = up_wreq && (WR_LATENCY == 0);
        else if (wr_state == ST_WAIT)
            wr_go = (wr_cnt == 4'd0);
        wr_hit = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_hit[i] = wr_go && in_range(wr_addr_c) && (to_idx(wr_addr_c) == IDX_W'(i));
    end

    always_comb begin
        rd_addr_c = (rd_state == ST_IDLE) ? up_raddr : raddr_q;
        rd_go     = 1'b0;
        if (rd_state == ST_IDLE)
            rd_go = up_rreq && (RD_LATENCY == 0);
        else if (rd_state == ST_WAIT)
            rd_go = (rd_cnt == 4'd0);
        rd_hit = '0;
        for (int i = 0; i < NUM_REGS; i++)
            rd_hit[i] = rd_go && in_range(rd_addr_c) && (to_idx(rd_addr_c) == IDX_W'(i));
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_hit[i]) rd_val = rd_val | rd_src[i];
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wr_state      <= ST_IDLE;
            wr_cnt        <= 4'd0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            up_wack       <= 1'b0;
            reg_wr_strobe <= '0;
        end else begin
            up_wack       <= wr_go;
            reg_wr_strobe <= wr_hit;
            case (wr_state)
                ST_IDLE: begin
                    if (up_wreq) begin
                        waddr_q  <= up_waddr;
                        wdata_q  <= up_wdata;
                        wr_cnt   <= (WR_LATENCY == 0) ? 4'd0 : WR_LAT - 4'd1;
                        wr_state <= (WR_LATENCY == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wr_cnt == 4'd0) wr_state <= ST_ACK;
                    else                wr_cnt   <= wr_cnt - 4'd1;
                end
                ST_ACK:  wr_state <= ST_IDLE;
                default: wr_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            rd_state      <= ST_IDLE;
            rd_cnt        <= 4'd0;
            raddr_q       <= '0;
            up_rack       <= 1'b0;
            up_rdata      <= '0;
            reg_rd_strobe <= '0;
        end else begin
            up_rack       <= rd_go;
            up_rdata      <= rd_go ? rd_val : 32'd0;
            reg_rd_strobe <= rd_hit;
            case (rd_state)
                ST_IDLE: begin
                    if (up_rreq) begin
                        raddr_q  <= up_raddr;
                        rd_cnt   <= (RD_LATENCY == 0) ? 4'd0 : RD_LAT - 4'd1;
                        rd_state <= (RD_LATENCY == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_cnt == 4'd0) rd_state <= ST_ACK;
                    else                rd_cnt   <= rd_cnt - 4'd1;
                end
                ST_ACK:  rd_state <= ST_IDLE;
                default: rd_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [31:0] RST = RESET_VALUES[i*32 +: 32];
        if (RO_MASK[i]) begin : g_ro
            assign rd_src[i]             = reg_in[i*32 +: 32];
            assign reg_out[i*32 +: 32]   = 32'd0;
        end else begin : g_store
            logic [31:0] q, q_nxt;
            // Hardware set is OR-ed after the clear so a simultaneous set wins.
            always_comb begin
                q_nxt = q;
                if (wr_hit[i]) q_nxt = W1C_MASK[i] ? (q & ~wr_data_c) : wr_data_c;
                if (W1C_MASK[i]) q_nxt = q_nxt | hw_set[i*32 +: 32];
            end
            always_ff @(posedge up_clk or negedge up_rstn) begin
                if (!up_rstn) q <= RST;
                else          q <= q_nxt;
            end
            assign rd_src[i]           = q;
            assign reg_out[i*32 +: 32] = q;
        end
    end

endmodule
